// File: rtl/cpu_pkg.sv
// Shared CPU core constants: register-bank defaults and sequencer state encodings.
package cpu_pkg;
    localparam int REG_DW    = 16;
    localparam int REG_DEPTH = 16;
    localparam int REG_NREAD = 2;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR
    } rf_state_e;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: decode/writeback side is master, register file is slave.
interface regfile_mp_if
    import cpu_pkg::*;
#(
    parameter int DW    = REG_DW,
    parameter int AW    = $clog2(REG_DEPTH),
    parameter int NREAD = REG_NREAD
);
    logic                clr;
    logic                busy;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DW-1:0]       wdata;
    logic [NREAD*AW-1:0] raddr;
    logic [NREAD*DW-1:0] rdata;

    modport master (output clr, we, waddr, wdata, raddr, input busy, rdata);
    modport slave  (input clr, we, waddr, wdata, raddr, output busy, rdata);
endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: busy forces zero, then hardwired r0, then write bypass, then array.
module regfile_rdport #(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic          busy,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    input  logic [DW-1:0] mem_q,
    output logic [DW-1:0] rdata
);
    always_comb begin
        rdata = mem_q;
        if (busy)
            rdata = '0;
        else if ((ZERO_R0 != 0) && (raddr == '0))
            rdata = '0;
        else if ((BYPASS != 0) && we && (waddr == raddr))
            rdata = wdata;
    end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file. The array has no reset; a sequencer
// sweeps zeros into it one entry per cycle after reset or on a clear request.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DW      = REG_DW,
    parameter int DEPTH   = REG_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int NREAD   = REG_NREAD,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    rf_state_e     state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          busy;

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                if (bus.clr) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign busy     = (state == S_CLEAR);
    assign bus.busy = busy;

    // Single write port shared by the sweep and writeback; the array stays untouched while rst is held.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.waddr;
        mem_wd = bus.wdata;
        if (!rst) begin
            if (busy) begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = '0;
            end else begin
                mem_we = bus.we && !((ZERO_R0 != 0) && (bus.waddr == '0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.raddr[k*AW +: AW];

        regfile_rdport #(
            .DW      (DW),
            .AW      (AW),
            .BYPASS  (BYPASS),
            .ZERO_R0 (ZERO_R0)
        ) u_rd (
            .busy  (busy),
            .we    (bus.we),
            .waddr (bus.waddr),
            .wdata (bus.wdata),
            .raddr (ra),
            .mem_q (mem[ra]),
            .rdata (bus.rdata[k*DW +: DW])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Two register files (plain, and bypass + hardwired r0) driven identically and
// compared against a sweep-counter/array reference model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr, we;
    logic [3:0]  waddr, ra0, ra1;
    logic [15:0] wdata;

    int n_chk = 0;
    int n_err = 0;

    // reference: entries still to be swept, and array contents, per DUT (0 = plain, 1 = bypass + r0)
    int          left [2];
    logic [15:0] mm   [2][16];

    always #5 clk = ~clk;

    regfile_mp_if #(.DW(16), .AW(4), .NREAD(2)) if0 ();
    regfile_mp_if #(.DW(16), .AW(4), .NREAD(2)) if1 ();

    assign if0.clr = clr;  assign if1.clr = clr;
    assign if0.we = we;    assign if1.we = we;
    assign if0.waddr = waddr;  assign if1.waddr = waddr;
    assign if0.wdata = wdata;  assign if1.wdata = wdata;
    assign if0.raddr = {ra1, ra0};  assign if1.raddr = {ra1, ra0};

    regfile_mp #(.DW(16), .DEPTH(16), .NREAD(2), .BYPASS(0), .ZERO_R0(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    regfile_mp #(.DW(16), .DEPTH(16), .NREAD(2), .BYPASS(1), .ZERO_R0(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int d, input logic [3:0] a);
        if (left[d] > 0) return 16'h0;
        if (d == 1 && a == 4'd0) return 16'h0;
        if (d == 1 && we && waddr == a) return wdata;
        return mm[d][a];
    endfunction

    task automatic model_reset();
        left[0] = 16;
        left[1] = 16;
    endtask

    task automatic model_edge();
        if (rst) return;
        for (int d = 0; d < 2; d++) begin
            if (left[d] > 0) begin
                mm[d][16 - left[d]] = 16'h0;
                left[d]--;
            end else begin
                if (we && !(d == 1 && waddr == 4'd0)) mm[d][waddr] = wdata;
                if (clr) left[d] = 16;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy0"}, 32'(if0.busy), 32'(left[0] > 0));
        check({tag, ".busy1"}, 32'(if1.busy), 32'(left[1] > 0));
        check({tag, ".d0p0"}, 32'(if0.rdata[15:0]),  32'(exp_rd(0, ra0)));
        check({tag, ".d0p1"}, 32'(if0.rdata[31:16]), 32'(exp_rd(0, ra1)));
        check({tag, ".d1p0"}, 32'(if1.rdata[15:0]),  32'(exp_rd(1, ra0)));
        check({tag, ".d1p1"}, 32'(if1.rdata[31:16]), 32'(exp_rd(1, ra1)));
    endtask

    // inputs are set just after a negedge; check, take the edge, return at the next negedge
    task automatic step(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr = 0; we = 0; waddr = 0; wdata = 0; ra0 = 0; ra1 = 0;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check({tag, ".async_busy0"}, 32'(if0.busy), 32'd1);
        check({tag, ".async_busy1"}, 32'(if1.busy), 32'd1);
        check({tag, ".async_rd"}, 32'(if1.rdata), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) mm[d][a] = 16'h0;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst.busy0", 32'(if0.busy), 32'd1);
        check("rst.busy1", 32'(if1.busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // sweep after reset: writes dropped, reads forced to zero
        we = 1; waddr = 4'd3; wdata = 16'hBEEF; ra0 = 4'd3; ra1 = 4'd3;
        for (int i = 0; i < 16; i++) begin
            #1 check("sweep.busy", 32'(if0.busy), 32'd1);
            check("sweep.rd0", 32'(if0.rdata), 32'd0);
            check("sweep.rd1", 32'(if1.rdata), 32'd0);
            step("sweep");
        end
        we = 0;
        #1 check("sweep.done", 32'(if0.busy), 32'd0);
        check("sweep.addr3", 32'(if0.rdata[15:0]), 32'h0000);
        step("post_sweep");

        // write then read: plain sees old value this cycle, bypass sees new
        we = 1; waddr = 4'd5; wdata = 16'h1234; ra0 = 4'd5; ra1 = 4'd5;
        #1 check("raw.old", 32'(if0.rdata[15:0]), 32'h0000);
        check("raw.byp", 32'(if1.rdata[15:0]), 32'h1234);
        step("raw");
        we = 0;
        #1 check("raw.new", 32'(if0.rdata), 32'h1234_1234);
        step("raw2");

        we = 1; waddr = 4'd7; wdata = 16'hA5A5; ra0 = 4'd6; ra1 = 4'd7;
        #1 check("byp.p1", 32'(if1.rdata[31:16]), 32'h0000A5A5);
        check("byp.p0", 32'(if1.rdata[15:0]), 32'h0000);
        step("byp");

        // hardwired r0 wins over bypass
        we = 1; waddr = 4'd0; wdata = 16'hFFFF; ra0 = 4'd0; ra1 = 4'd0;
        #1 check("r0.same", 32'(if1.rdata), 32'd0);
        step("r0");
        we = 0;
        #1 check("r0.later", 32'(if1.rdata), 32'd0);
        check("r0.plain", 32'(if0.rdata[15:0]), 32'h0000FFFF);
        step("r0b");

        // fill, then clear with a simultaneous write
        for (int i = 1; i < 16; i++) begin
            we = 1; waddr = 4'(i); wdata = 16'h0100 + 16'(i); ra0 = 4'(i); ra1 = 4'(i - 1);
            step("fill");
        end
        clr = 1; we = 1; waddr = 4'd2; wdata = 16'h0F0F; ra0 = 4'd2; ra1 = 4'd9;
        step("clr_edge");
        clr = 0; we = 0;
        for (int i = 0; i < 16; i++) begin
            #1 check("clr.busy", 32'(if0.busy), 32'd1);
            step("clr_sweep");
        end
        for (int a = 0; a < 16; a++) begin
            ra0 = 4'(a); ra1 = 4'(15 - a);
            #1 check("clr.zero0", 32'(if0.rdata), 32'd0);
            check("clr.zero1", 32'(if1.rdata), 32'd0);
            step("clr_read");
        end

        // reset in the middle of a sweep restarts a full sweep
        we = 1; waddr = 4'd4; wdata = 16'h4444;
        step("pre_clr");
        clr = 1; we = 0;
        step("clr2");
        clr = 0;
        for (int i = 0; i < 8; i++) step("mid_sweep");
        async_reset("midrst");
        for (int i = 0; i < 16; i++) begin
            #1 check("midrst.busy", 32'(if1.busy), 32'd1);
            step("midrst_sweep");
        end
        #1 check("midrst.done", 32'(if1.busy), 32'd0);

        // reset from idle between edges must raise busy immediately
        we = 1; waddr = 4'd9; wdata = 16'h9999;
        step("pre_idle_rst");
        we = 0;
        async_reset("idlerst");
        for (int i = 0; i < 16; i++) step("idlerst_sweep");

        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 1500; i++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            wdata = 16'($urandom);
            ra0   = 4'($urandom_range(0, 15));
            ra1   = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            clr   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 299) == 0) begin
                clr = 0;
                async_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
